poly_shift_reg: RTL
===================

Name: poly_shift_reg

Overview:
- Parametrised polynomial/shift-register unit for the POKEY core, replacing per-bit chains of single-bit load/preset/reset cells.
- Holds a WIDTH-bit register with parallel load, preset-to-ones, serial-shift mode and LFSR mode.
- LFSR mode has a selectable short length (e.g. 17-bit/9-bit poly select, as done by AUDCTL).
- Feeds noise/distortion selection and the RANDOM register path.

Parameters:
- WIDTH, 17, full register length (>=3).
- ALT_WIDTH, 9, register length in short mode (2..WIDTH-1).
- TAP_MASK, 17'h00009, feedback taps for full mode (x^17+x^3+1); bit i set means q[i] is XORed into feedback.
- ALT_TAP_MASK, 9'h011, feedback taps for short mode (x^9+x^4+1); bits >= ALT_WIDTH are ignored.
- RESET_VAL, 1, register value after reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- reset  input  1  synchronous, active-high reset.
- enn  input  1  step enable (clock-divider tick); gates load, preset and shift.
- lfsr_en  input  1  1 = LFSR feedback; 0 = serial shift from sin.
- short_mode  input  1  1 = ALT_WIDTH length/taps; 0 = WIDTH length/taps.
- ld  input  1  parallel load request.
- d  input  WIDTH  parallel load data.
- preset  input  1  set active bits to 1.
- sin  input  1  serial input for shift mode.
- q  output  WIDTH  register contents.
- sout  output  1  q[0], combinational from the register.
- wrap  output  1  registered one-cycle pulse on LFSR period completion.

Behaviour:
- L = short_mode ? ALT_WIDTH : WIDTH. M = short_mode ? ALT_TAP_MASK : TAP_MASK. The active field is q[L-1:0].
- Per falling clk edge, first match wins:
  1. reset: q = RESET_VAL, wrap = 0.
  2. enn = 0: hold q; wrap = 0.
  3. preset: q[L-1:0] = all ones; q[WIDTH-1:L] = 0.
  4. ld: q = d (all WIDTH bits); in short mode, bits >= L are then forced to 0.
  5. Otherwise shift right: q[L-2:0] = q[L-1:1]; q[L-1] = nb; q[WIDTH-1:L] = 0.
- nb = lfsr_en ? fb : sin.
- fb = XOR-reduce(q & M), restricted to the active field.
- Lockup escape: if lfsr_en and q[L-1:0] == 0, then fb = 1.
- wrap: set to 1 on a shift step with lfsr_en = 1 when the new q[L-1:0] equals RESET_VAL[L-1:0]; otherwise 0. Never set by a load or preset.
- short_mode change mid-run:
  - takes effect at the next enabled edge;
  - bits >= ALT_WIDTH are cleared on that step;
  - no other state is lost.
- lfsr_en change mid-run: takes effect at the next step; contents are retained.
- Reset mid-operation overrides everything, including enn = 0.
- Latency: q and sout reflect an operation one edge after it is sampled. wrap is aligned with the q update it describes.
- Period in LFSR mode: 2^L - 1 for maximal taps. Defaults give 131071 (full) and 511 (short).

Decomposition:
- Shared pokey package constants:
  - POLY17_TAPS, POLY9_TAPS, POLY5_TAPS, POLY4_TAPS;
  - their widths;
  - default RESET_VAL.
- One sub-module, poly_fb: combinational masked XOR-reduce plus lockup-escape detect. Parametrised on WIDTH; inputs q, mask, L.
- The top level owns the priority mux, shift and wrap register.

Test Plan:
- Reset/first step: WIDTH=5, TAP_MASK=5'h05, RESET_VAL=1, lfsr_en=1, enn=1 -> q=01 after reset, then 10, then 08. wrap pulses exactly once after 31 enabled steps, with q back at 01.
- Short mode period: same bench, ALT_WIDTH=4, ALT_TAP_MASK=4'h3, short_mode=1 -> q[4]=0 throughout, period 15, all 15 nonzero 4-bit states visited, wrap every 15 steps.
- Priority: assert reset, preset and ld together with enn=0 -> q=RESET_VAL. Then preset+ld with enn=1, d=5'h0A -> q=5'h1F. Then ld alone -> q=5'h0A.
- Lockup/enable: ld d=0, then step in LFSR mode -> q=5'h10. Hold enn=0 for 10 edges -> q unchanged, wrap stays 0.
- Serial mode: lfsr_en=0, sin pattern 1,0,1,1,0 from q=0 -> q=5'h0D, and sout sequence matches the delayed input.
- Defaults: WIDTH=17, RESET_VAL=1, run 131071 steps -> exactly one wrap. Switch short_mode=1 mid-run -> q[16:9]=0 after one step, wrap period 511 thereafter.

Source files
------------

// File: rtl/poly_shift_reg_pkg.sv
// poly_shift_reg_pkg
//   Shared POKEY polynomial constants (tap masks and register lengths), the
//   default register value after reset, and the step-operation encoding
//   used by the polynomial/shift-register unit.
package poly_shift_reg_pkg;

  // Tap masks: bit i set means q[i] feeds the XOR feedback.
  localparam int          POLY17_W    = 17;
  localparam logic [16:0] POLY17_TAPS = 17'h00009;  // x^17 + x^3 + 1
  localparam int          POLY9_W     = 9;
  localparam logic [8:0]  POLY9_TAPS  = 9'h011;     // x^9 + x^4 + 1
  localparam int          POLY5_W     = 5;
  localparam logic [4:0]  POLY5_TAPS  = 5'h05;      // x^5 + x^2 + 1
  localparam int          POLY4_W     = 4;
  localparam logic [3:0]  POLY4_TAPS  = 4'h3;       // x^4 + x + 1

  localparam int DEFAULT_RESET_VAL = 1;

  // Operation selected for an enabled (or idle) step.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_PRESET = 2'd1,
    OP_LOAD   = 2'd2,
    OP_SHIFT  = 2'd3
  } polyOp_e;

endpackage

// File: rtl/poly_shift_reg_if.sv
// poly_shift_reg_if
//   Control/data bundle of the polynomial shift register.
//   master: step enable, mode selects, load/preset requests, serial input;
//           observes q, sout and wrap.
//   slave : the register unit itself.
interface poly_shift_reg_if
  import poly_shift_reg_pkg::*;
#(
  parameter int WIDTH = POLY17_W
);
  logic             enn;
  logic             lfsr_en;
  logic             short_mode;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             preset;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             wrap;

  modport master (
    output enn, lfsr_en, short_mode, ld, d, preset, sin,
    input  q, sout, wrap
  );

  modport slave (
    input  enn, lfsr_en, short_mode, ld, d, preset, sin,
    output q, sout, wrap
  );
endinterface

// File: rtl/poly_shift_reg_fb.sv
// poly_fb
//   Combinational feedback for the polynomial register: XOR of the tapped
//   bits inside the active field q[len-1:0], plus a flag telling that the
//   active field is all zero (the LFSR lockup state).
//   q      : register contents
//   mask   : tap mask (bits at or above len are ignored)
//   len    : active field length
//   fb     : masked XOR-reduce of the active field
//   lockup : 1 when q[len-1:0] is all zero
module poly_fb #(
  parameter int WIDTH = 17,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mask,
  input  logic [LW-1:0]    len,
  output logic             fb,
  output logic             lockup
);

  always_comb begin
    fb     = 1'b0;
    lockup = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(len)) begin
        fb = fb ^ (q[i] & mask[i]);
        if (q[i]) lockup = 1'b0;
      end
    end
  end

endmodule

// File: rtl/poly_shift_reg.sv
// poly_shift_reg
//   WIDTH-bit polynomial/shift register for the POKEY noise and RANDOM paths.
//   Supports parallel load, preset-to-ones, serial shift from sin and LFSR
//   mode with a selectable short length (ALT_WIDTH / ALT_TAP_MASK).
//   All state changes on the falling edge of clk.
//   clk   : system clock (falling edge active)
//   reset : synchronous, active-high; loads RESET_VAL and clears wrap
//   bus   : slave side of poly_shift_reg_if (enn, lfsr_en, short_mode, ld,
//           d, preset, sin in; q, sout = q[0], wrap pulse out)
module poly_shift_reg
  import poly_shift_reg_pkg::*;
#(
  parameter int                   WIDTH        = POLY17_W,
  parameter int                   ALT_WIDTH    = POLY9_W,
  parameter logic [WIDTH-1:0]     TAP_MASK     = WIDTH'(POLY17_TAPS),
  parameter logic [ALT_WIDTH-1:0] ALT_TAP_MASK = ALT_WIDTH'(POLY9_TAPS),
  parameter logic [WIDTH-1:0]     RESET_VAL    = WIDTH'(DEFAULT_RESET_VAL)
) (
  input logic             clk,
  input logic             reset,
  poly_shift_reg_if.slave bus
);

  localparam int               LW         = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] FULL_FIELD = '1;
  localparam logic [WIDTH-1:0] ALT_FIELD  = {{(WIDTH-ALT_WIDTH){1'b0}}, {ALT_WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] ALT_TAPS   = {{(WIDTH-ALT_WIDTH){1'b0}}, ALT_TAP_MASK};

  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] qNext;
  logic [WIDTH-1:0] field;
  logic [WIDTH-1:0] mask;
  logic [LW-1:0]    len;
  logic             fb;
  logic             lockup;
  logic             nb;
  logic             wrapReg;
  logic             wrapNext;
  polyOp_e          op;

  assign len   = bus.short_mode ? LW'(ALT_WIDTH) : LW'(WIDTH);
  assign field = bus.short_mode ? ALT_FIELD : FULL_FIELD;
  assign mask  = bus.short_mode ? ALT_TAPS : TAP_MASK;

  poly_fb #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) uFb (
    .q      (qReg),
    .mask   (mask),
    .len    (len),
    .fb     (fb),
    .lockup (lockup)
  );

  // An all-zero active field would stick forever; inject a 1 instead.
  assign nb = bus.lfsr_en ? (fb | lockup) : bus.sin;

  always_comb begin
    op = OP_SHIFT;
    if (!bus.enn)        op = OP_HOLD;
    else if (bus.preset) op = OP_PRESET;
    else if (bus.ld)     op = OP_LOAD;
  end

  // Every non-hold step rewrites the bits above the active field with zero,
  // which is how a switch into short mode clears them on its first step.
  always_comb begin
    qNext    = qReg;
    wrapNext = 1'b0;
    case (op)
      OP_HOLD:   qNext = qReg;
      OP_PRESET: qNext = field;
      OP_LOAD:   qNext = bus.d & field;
      OP_SHIFT: begin
        qNext = (qReg >> 1) & field;
        if (bus.short_mode) qNext[ALT_WIDTH-1] = nb;
        else                qNext[WIDTH-1]     = nb;
        wrapNext = bus.lfsr_en && (qNext == (RESET_VAL & field));
      end
      default:   qNext = qReg;
    endcase
  end

  // Register stage: q and wrap update together on the falling edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      qReg    <= RESET_VAL;
      wrapReg <= 1'b0;
    end else begin
      qReg    <= qNext;
      wrapReg <= wrapNext;
    end
  end

  assign bus.q    = qReg;
  assign bus.sout = qReg[0];
  assign bus.wrap = wrapReg;

endmodule
